h_drv: RTL and testbench



---
 rtl/h_drv.sv | 206 ++++++++++++++++++++
 tb/tb_h_drv.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_drv.sv
// Hash-table initiator driver: issues tagged client requests as table commands and
// pairs in-order table responses with their tags. Optional watchdog: H_DRV_WDOG_EN.
package h_pkg;
   typedef enum logic [1:0] {OP_GET = 2'd0, OP_PUT = 2'd1, OP_DEL = 2'd2, OP_NOP = 2'd3} opcode_t;
   typedef enum logic [1:0] {ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_ERR = 2'd3} status_t;
   typedef logic [15:0] k_t;
   typedef logic [31:0] v_t;
   typedef struct packed {
      status_t status;
      v_t      v;
   } rsp_t;
endpackage

module h_drv #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_vld,
   output logic                       req_rdy,
   input  h_pkg::opcode_t             req_opcode,
   input  h_pkg::k_t                  req_k,
   input  h_pkg::v_t                  req_v,
   input  logic [TAG_W-1:0]           req_tag,
   output logic                       cmd_vld,
   output h_pkg::opcode_t             cmd_opcode,
   output h_pkg::k_t                  cmd_k,
   output h_pkg::v_t                  cmd_v,
   input  logic                       rsp_vld,
   input  h_pkg::status_t             rsp_status,
   input  h_pkg::v_t                  rsp_v,
   output logic                       cpl_vld,
   input  logic                       cpl_rdy,
   output logic [TAG_W-1:0]           cpl_tag,
   output h_pkg::status_t             cpl_status,
   output h_pkg::v_t                  cpl_v,
   output logic [$clog2(DEPTH):0]     occ,
   output logic                       err_unexp,
   output logic                       err_wdog
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      h_pkg::rsp_t      rsp;
   } cpl_t;

   logic [CNT_W-1:0] credits_q, credits_d;
   logic             req_rdy_q, req_rdy_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             cmd_vld_q, cmd_vld_d;
   h_pkg::opcode_t   cmd_opcode_q, cmd_opcode_d;
   h_pkg::k_t        cmd_k_q, cmd_k_d;
   h_pkg::v_t        cmd_v_q, cmd_v_d;
   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   logic [TAG_W-1:0] tag_mem_d [DEPTH];
   logic [CNT_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   cpl_t             cpl_mem_q [DEPTH];
   cpl_t             cpl_mem_d [DEPTH];
   logic [CNT_W-1:0] cpl_wr_q, cpl_wr_d, cpl_rd_q, cpl_rd_d;
   logic             cpl_vld_q, cpl_vld_d;
   cpl_t             cpl_head_q, cpl_head_d;
   logic             err_unexp_q, err_unexp_d;

   logic accept, pop, tag_empty, rsp_take;
   cpl_t new_cpl;

   // Credits, issue path and both FIFOs; cpl head is re-registered from the post-update memory
   always_comb begin
      accept    = req_vld && req_rdy_q;
      pop       = cpl_vld_q && cpl_rdy;
      tag_empty = (tag_wr_q == tag_rd_q);
      rsp_take  = rsp_vld && !tag_empty;

      credits_d = credits_q;
      if (accept && !pop)
         credits_d = credits_q - CNT_W'(1);
      else if (pop && !accept)
         credits_d = credits_q + CNT_W'(1);
      req_rdy_d = (credits_d != '0);
      occ_d     = CNT_W'(DEPTH) - credits_d;

      cmd_vld_d    = accept;
      cmd_opcode_d = cmd_opcode_q;
      cmd_k_d      = cmd_k_q;
      cmd_v_d      = cmd_v_q;
      if (accept) begin
         cmd_opcode_d = req_opcode;
         cmd_k_d      = req_k;
         cmd_v_d      = req_v;
      end

      tag_mem_d = tag_mem_q;
      tag_wr_d  = tag_wr_q;
      tag_rd_d  = tag_rd_q;
      if (accept) begin
         tag_mem_d[tag_wr_q[PTR_W-1:0]] = req_tag;
         tag_wr_d = tag_wr_q + CNT_W'(1);
      end
      if (rsp_take)
         tag_rd_d = tag_rd_q + CNT_W'(1);

      new_cpl.tag        = tag_mem_q[tag_rd_q[PTR_W-1:0]];
      new_cpl.rsp.status = rsp_status;
      new_cpl.rsp.v      = rsp_v;

      cpl_mem_d = cpl_mem_q;
      cpl_wr_d  = cpl_wr_q;
      cpl_rd_d  = cpl_rd_q;
      if (rsp_take) begin
         cpl_mem_d[cpl_wr_q[PTR_W-1:0]] = new_cpl;
         cpl_wr_d = cpl_wr_q + CNT_W'(1);
      end
      if (pop)
         cpl_rd_d = cpl_rd_q + CNT_W'(1);
      cpl_vld_d  = (cpl_wr_d != cpl_rd_d);
      cpl_head_d = cpl_mem_d[cpl_rd_d[PTR_W-1:0]];

      err_unexp_d = err_unexp_q || (rsp_vld && tag_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q    <= CNT_W'(DEPTH);
         req_rdy_q    <= 1'b0;
         occ_q        <= '0;
         cmd_vld_q    <= 1'b0;
         cmd_opcode_q <= h_pkg::OP_GET;
         cmd_k_q      <= '0;
         cmd_v_q      <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         cpl_wr_q     <= '0;
         cpl_rd_q     <= '0;
         cpl_vld_q    <= 1'b0;
         cpl_head_q   <= '0;
         err_unexp_q  <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         req_rdy_q    <= req_rdy_d;
         occ_q        <= occ_d;
         cmd_vld_q    <= cmd_vld_d;
         cmd_opcode_q <= cmd_opcode_d;
         cmd_k_q      <= cmd_k_d;
         cmd_v_q      <= cmd_v_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         cpl_wr_q     <= cpl_wr_d;
         cpl_rd_q     <= cpl_rd_d;
         cpl_vld_q    <= cpl_vld_d;
         cpl_head_q   <= cpl_head_d;
         err_unexp_q  <= err_unexp_d;
      end
   end

   // Storage arrays need no reset; pointers define validity
   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
      cpl_mem_q <= cpl_mem_d;
   end

`ifdef H_DRV_WDOG_EN
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            err_wdog_q, err_wdog_d;

   // Counts cycles spent waiting on an outstanding response; saturates at threshold
   always_comb begin
      wdog_d = '0;
      if (!tag_empty && !rsp_vld)
         wdog_d = (wdog_q == WD_W'(WDOG_CYCLES)) ? wdog_q : wdog_q + WD_W'(1);
      err_wdog_d = err_wdog_q || (wdog_d == WD_W'(WDOG_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q     <= '0;
         err_wdog_q <= 1'b0;
      end else begin
         wdog_q     <= wdog_d;
         err_wdog_q <= err_wdog_d;
      end
   end

   assign err_wdog = err_wdog_q;
`else
   assign err_wdog = 1'b0 & (WDOG_CYCLES != 0);
`endif

   assign req_rdy    = req_rdy_q;
   assign occ        = occ_q;
   assign cmd_vld    = cmd_vld_q;
   assign cmd_opcode = cmd_opcode_q;
   assign cmd_k      = cmd_k_q;
   assign cmd_v      = cmd_v_q;
   assign cpl_vld    = cpl_vld_q;
   assign cpl_tag    = cpl_head_q.tag;
   assign cpl_status = cpl_head_q.rsp.status;
   assign cpl_v      = cpl_head_q.rsp.v;
   assign err_unexp  = err_unexp_q;

endmodule

// File: tb/tb_h_drv.sv
// Self-checking bench for h_drv: queue-based reference model compared every cycle,
// with directed scenarios pinned by literal expectations plus a randomized phase.
module tb_h_drv;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned WDOG  = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 req_vld = 1'b0;
   logic                 req_rdy;
   h_pkg::opcode_t       req_opcode = h_pkg::OP_GET;
   h_pkg::k_t            req_k = '0;
   h_pkg::v_t            req_v = '0;
   logic [TAG_W-1:0]     req_tag = '0;
   logic                 cmd_vld;
   h_pkg::opcode_t       cmd_opcode;
   h_pkg::k_t            cmd_k;
   h_pkg::v_t            cmd_v;
   logic                 rsp_vld = 1'b0;
   h_pkg::status_t       rsp_status = h_pkg::ST_OK;
   h_pkg::v_t            rsp_v = '0;
   logic                 cpl_vld;
   logic                 cpl_rdy = 1'b0;
   logic [TAG_W-1:0]     cpl_tag;
   h_pkg::status_t       cpl_status;
   h_pkg::v_t            cpl_v;
   logic [$clog2(DEPTH):0] occ;
   logic                 err_unexp;
   logic                 err_wdog;

   h_drv #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WDOG_CYCLES(WDOG)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_opcode(req_opcode), .req_k(req_k),
      .req_v(req_v), .req_tag(req_tag),
      .cmd_vld(cmd_vld), .cmd_opcode(cmd_opcode), .cmd_k(cmd_k), .cmd_v(cmd_v),
      .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_v(rsp_v),
      .cpl_vld(cpl_vld), .cpl_rdy(cpl_rdy), .cpl_tag(cpl_tag), .cpl_status(cpl_status),
      .cpl_v(cpl_v), .occ(occ), .err_unexp(err_unexp), .err_wdog(err_wdog)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [1:0]       st;
      logic [31:0]      v;
   } mcpl_t;

   // Reference model state
   logic [TAG_W-1:0] m_tagq[$];
   mcpl_t            m_cplq[$];
   int               m_credits = DEPTH;
   bit               m_rdy = 0;
   bit               m_cmd_vld = 0;
   logic [1:0]       m_op = '0;
   logic [15:0]      m_k = '0;
   logic [31:0]      m_v = '0;
   bit               m_err_unexp = 0;
   bit               m_err_wdog = 0;
   int               m_wdog = 0;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance the model one clock edge from the inputs present at that edge
   task automatic model_step();
      bit acc, pop;
      bit tag_nonempty;
      mcpl_t c;
      if (rst) begin
         m_tagq.delete();
         m_cplq.delete();
         m_credits = DEPTH;
         m_rdy = 0; m_cmd_vld = 0;
         m_op = '0; m_k = '0; m_v = '0;
         m_err_unexp = 0; m_err_wdog = 0; m_wdog = 0;
         return;
      end
      tag_nonempty = (m_tagq.size() > 0);
      acc = req_vld && m_rdy;
      pop = (m_cplq.size() > 0) && cpl_rdy;
      if (pop) void'(m_cplq.pop_front());
      if (rsp_vld) begin
         if (tag_nonempty) begin
            c.tag = m_tagq.pop_front();
            c.st  = rsp_status;
            c.v   = rsp_v;
            m_cplq.push_back(c);
         end else begin
            m_err_unexp = 1;
         end
      end
      if (acc) begin
         m_tagq.push_back(req_tag);
         m_op = req_opcode; m_k = req_k; m_v = req_v;
      end
      m_cmd_vld = acc;
      m_credits = m_credits - int'(acc) + int'(pop);
      m_rdy = (m_credits != 0);
      if (tag_nonempty && !rsp_vld) m_wdog = (m_wdog < WDOG) ? m_wdog + 1 : WDOG;
      else m_wdog = 0;
      if (m_wdog == WDOG) m_err_wdog = 1;
   endtask

   task automatic compare();
      chk("req_rdy", 64'(req_rdy), 64'(m_rdy));
      chk("cmd_vld", 64'(cmd_vld), 64'(m_cmd_vld));
      if (m_cmd_vld) begin
         chk("cmd_opcode", 64'(cmd_opcode), 64'(m_op));
         chk("cmd_k", 64'(cmd_k), 64'(m_k));
         chk("cmd_v", 64'(cmd_v), 64'(m_v));
      end
      chk("cpl_vld", 64'(cpl_vld), 64'(m_cplq.size() > 0));
      if (m_cplq.size() > 0) begin
         chk("cpl_tag", 64'(cpl_tag), 64'(m_cplq[0].tag));
         chk("cpl_status", 64'(cpl_status), 64'(m_cplq[0].st));
         chk("cpl_v", 64'(cpl_v), 64'(m_cplq[0].v));
      end
      chk("occ", 64'(occ), 64'(DEPTH - m_credits));
      chk("err_unexp", 64'(err_unexp), 64'(m_err_unexp));
`ifdef H_DRV_WDOG_EN
      chk("err_wdog", 64'(err_wdog), 64'(m_err_wdog));
`else
      chk("err_wdog", 64'(err_wdog), 64'(0));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   // Table-side responder: answers an outstanding command with probability prob%
   task automatic set_rsp(input int prob);
      if (m_tagq.size() > 0 && $urandom_range(0, 99) < prob) begin
         rsp_vld    = 1'b1;
         rsp_status = h_pkg::status_t'(2'($urandom_range(0, 3)));
         rsp_v      = $urandom;
      end else begin
         rsp_vld = 1'b0;
      end
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick(); tick();
      chk("rst occ", 64'(occ), 64'(0));
      chk("rst req_rdy", 64'(req_rdy), 64'(0));
      chk("rst cmd_k", 64'(cmd_k), 64'(0));
      chk("rst cpl_tag", 64'(cpl_tag), 64'(0));
      rst = 1'b0;
      tick();
      chk("post-rst req_rdy", 64'(req_rdy), 64'(1));

      // Single lookup
      req_vld = 1'b1; req_opcode = h_pkg::OP_GET; req_k = 16'h0012; req_v = '0; req_tag = 4'd3;
      tick();
      req_vld = 1'b0;
      chk("lookup cmd_vld", 64'(cmd_vld), 64'(1));
      chk("lookup cmd_k", 64'(cmd_k), 64'h12);
      tick();
      chk("lookup cmd_vld one cycle", 64'(cmd_vld), 64'(0));
      tick(); tick();
      rsp_vld = 1'b1; rsp_status = h_pkg::ST_OK; rsp_v = 32'hAB;
      tick();
      rsp_vld = 1'b0;
      chk("lookup cpl_vld", 64'(cpl_vld), 64'(1));
      chk("lookup cpl_tag", 64'(cpl_tag), 64'(3));
      chk("lookup cpl_v", 64'(cpl_v), 64'hAB);
      chk("lookup occ busy", 64'(occ), 64'(1));
      cpl_rdy = 1'b1;
      tick();
      cpl_rdy = 1'b0;
      chk("lookup occ after pop", 64'(occ), 64'(0));
      chk("lookup cpl_vld after pop", 64'(cpl_vld), 64'(0));

      // Credit exhaustion with cpl_rdy low
      for (int i = 0; i < 4; i++) begin
         req_vld = 1'b1; req_tag = 4'(i); req_k = 16'(100 + i); req_v = 32'(i);
         req_opcode = h_pkg::OP_PUT;
         tick();
      end
      req_tag = 4'd4;
      for (int i = 0; i < 8; i++) begin
         set_rsp(100);
         tick();
      end
      rsp_vld = 1'b0;
      chk("exhaust occ", 64'(occ), 64'(4));
      chk("exhaust req_rdy", 64'(req_rdy), 64'(0));
      chk("exhaust cpl_tag", 64'(cpl_tag), 64'(0));
      cpl_rdy = 1'b1;
      tick();
      chk("drain cpl_tag", 64'(cpl_tag), 64'(1));
      chk("drain occ", 64'(occ), 64'(3));
      chk("drain req_rdy", 64'(req_rdy), 64'(1));
      tick();
      chk("acc+pop occ", 64'(occ), 64'(3));
      chk("acc+pop req_rdy", 64'(req_rdy), 64'(1));
      chk("acc+pop cmd_vld", 64'(cmd_vld), 64'(1));
      chk("acc+pop cpl_tag", 64'(cpl_tag), 64'(2));
      req_tag = 4'd5;
      tick();
      req_vld = 1'b0;
      for (int i = 0; i < 12; i++) begin
         set_rsp(100);
         tick();
      end
      rsp_vld = 1'b0;
      chk("drained occ", 64'(occ), 64'(0));

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         req_vld    = ($urandom_range(0, 99) < 60);
         req_opcode = h_pkg::opcode_t'(2'($urandom_range(0, 3)));
         req_k      = 16'($urandom);
         req_v      = $urandom;
         req_tag    = 4'($urandom);
         cpl_rdy    = ($urandom_range(0, 99) < 65);
         set_rsp(50);
         tick();
      end
      req_vld = 1'b0; rsp_vld = 1'b0; cpl_rdy = 1'b0;

      // Reset with requests outstanding, then a late response
      rst = 1'b1; tick(); rst = 1'b0; tick();
      req_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_tag = 4'(8 + i);
         tick();
      end
      req_vld = 1'b0;
      chk("pre-rst occ", 64'(occ), 64'(3));
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid-rst occ", 64'(occ), 64'(0));
      chk("mid-rst cpl_vld", 64'(cpl_vld), 64'(0));
      tick();
      chk("mid-rst req_rdy", 64'(req_rdy), 64'(1));
      rsp_vld = 1'b1; rsp_v = 32'h55;
      tick();
      rsp_vld = 1'b0;
      chk("unexp err", 64'(err_unexp), 64'(1));
      chk("unexp no cpl", 64'(cpl_vld), 64'(0));
      chk("unexp occ", 64'(occ), 64'(0));
      for (int i = 0; i < 4; i++) tick();
      chk("unexp sticky", 64'(err_unexp), 64'(1));

      // Watchdog: one request, no response
      rst = 1'b1; tick(); rst = 1'b0; tick();
      chk("unexp cleared", 64'(err_unexp), 64'(0));
      req_vld = 1'b1; req_tag = 4'd7;
      tick();
      req_vld = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("wdog early", 64'(err_wdog), 64'(0));
      for (int i = 0; i < 10; i++) tick();
`ifdef H_DRV_WDOG_EN
      chk("wdog fired", 64'(err_wdog), 64'(1));
`else
      chk("wdog off", 64'(err_wdog), 64'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
